gshare_predictor: RTL and testbench
===================================

Name: gshare_predictor

Overview:
- Parametrised successor to the local saturating-counter predictor. Global-history (gshare) direction predictor for the fetch stage.
- Pattern history table (PHT) of N-bit saturating counters, indexed by instruction address XOR speculative global history register (GHR).
- Speculative GHR update at predict time; checkpoint/restore on mispredict from the commit/branch-resolve side.
- Sits between instruction fetch (predict port) and the branch resolution unit (update port).

Parameters:
- PHT_WIDTH, 10, PHT index bits; table depth = 2**PHT_WIDTH.
- GHR_WIDTH, 8, global history length; legal range 1..PHT_WIDTH.
- CTR_WIDTH, 2, saturating counter width; legal range 2..4.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  ready; all state frozen and outputs held when low
- pred_valid  input  1  fetch requests a prediction this cycle
- pred_addr  input  32  branch instruction address
- pred_out_valid  output  1  prediction result valid (registered)
- pred_taken  output  1  predicted direction, 1 = jump
- pred_ghr  output  GHR_WIDTH  GHR snapshot used for this prediction; carried with the branch
- upd_valid  input  1  resolved branch update this cycle
- upd_addr  input  32  address of the resolved branch
- upd_ghr  input  GHR_WIDTH  snapshot returned from pred_ghr for that branch
- upd_taken  input  1  actual direction
- upd_mispredict  input  1  predicted direction was wrong; qualified by upd_valid

Behaviour:
- Clock and reset: one clock (clk_in); reset (rst_in) is synchronous and active-high. Reset has priority over rdy_in.
- Reset values:
  - Every PHT counter = 2**(CTR_WIDTH-1)-1 (weakly not-taken; 01 for CTR_WIDTH=2).
  - GHR = 0; pred_out_valid = 0; pred_taken = 0; pred_ghr = 0.
- Index function:
  - idx(addr, h) = addr[PHT_WIDTH+1:2] XOR zero-extend(h) to PHT_WIDTH bits.
  - Prediction reads counter MSB.
- Predict path, 1-cycle latency:
  - Cycle T: pred_valid=1 with rdy_in=1.
  - Cycle T+1: pred_out_valid=1, pred_taken = MSB of PHT[idx(pred_addr, GHR_T)], pred_ghr = GHR_T.
  - When pred_valid=0, pred_out_valid drops to 0 next cycle; pred_taken/pred_ghr hold their last values.
- Speculative GHR: on an accepted prediction, GHR <= {GHR[GHR_WIDTH-2:0], predicted bit} at the end of cycle T.
- Update path, counter write at end of the upd_valid cycle:
  - Target counter: PHT[idx(upd_addr, upd_ghr)].
  - taken: increment, saturate at 2**CTR_WIDTH-1.
  - not taken: decrement, saturate at 0. No wrap-around.
- Mispredict recovery: upd_valid & upd_mispredict sets GHR <= {upd_ghr[GHR_WIDTH-2:0], upd_taken}.
- Simultaneous events:
  - Mispredict and pred_valid in the same cycle: the restore wins for GHR and the speculative shift is discarded. The prediction is still produced from the pre-restore GHR (fetch is flushing anyway).
  - Update and prediction hitting the same PHT index: the prediction sees the old counter value (read-before-write); the update is not lost.
  - upd_valid without mispredict: the GHR is not touched.
- rdy_in low:
  - No PHT write and no GHR change.
  - Output registers hold.
  - pred_valid/upd_valid in that cycle are ignored, not queued.
- Reset mid-operation: all state returns to reset values on the next edge; in-flight predictions are dropped (pred_out_valid=0).
- Storage: PHT is a register array of 2**PHT_WIDTH x CTR_WIDTH. A single read port and a single write port per cycle suffice.

Test Plan:
- Reset, then predict addr 0x0000_1000 -> T+1: pred_out_valid=1, pred_taken=0, pred_ghr=0; GHR stays 0 after the not-taken shift.
- Two taken updates at addr 0x1000, upd_ghr=0, counter 01->10->11 -> next predict at 0x1000 with GHR=0 gives pred_taken=1, pred_ghr=0x00; a third taken update leaves the counter at 11 (saturation).
- Four not-taken updates on the same entry -> counter at 00, no underflow wrap; prediction = 0.
- Predict taken three times (preloaded counters) -> GHR = 0x07; then upd_valid=1, upd_mispredict=1, upd_ghr=0x01, upd_taken=0 -> GHR = 0x02 the following cycle.
- Same-cycle update (taken, saturating entry 01->10) and predict to the same index -> that prediction returns 0; a repeat predict (same GHR forced via mispredict restore) returns 1.
- rdy_in=0 for 3 cycles with pred_valid=1 and upd_valid=1 asserted -> no counter/GHR change, outputs unchanged; rst_in pulse mid-stream -> all outputs 0, counters back to 01.

Source files
------------

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare global-history branch direction predictor
//
// Pattern history table of saturating counters, indexed by the branch
// address XOR the speculative global history register (GHR).
//
// Ports:
//   clk_in, rst_in   clock and synchronous active-high reset
//   rdy_in           global enable; when low, all state and outputs hold
//   pred_valid/addr  prediction request from fetch
//   pred_out_valid   registered prediction valid, one cycle after request
//   pred_taken       predicted direction (counter MSB)
//   pred_ghr         GHR snapshot used for the prediction
//   upd_valid/addr   resolved branch update from the resolve unit
//   upd_ghr          snapshot that travelled with the branch
//   upd_taken        actual direction
//   upd_mispredict   restore the GHR from upd_ghr and the actual direction
module gshare_predictor #(
    parameter int PHT_WIDTH = 10,
    parameter int GHR_WIDTH = 8,
    parameter int CTR_WIDTH = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 pred_valid,
    input  logic [31:0]          pred_addr,
    output logic                 pred_out_valid,
    output logic                 pred_taken,
    output logic [GHR_WIDTH-1:0] pred_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_addr,
    input  logic [GHR_WIDTH-1:0] upd_ghr,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict
);

    localparam int PHT_DEPTH = 1 << PHT_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;

    logic [CTR_WIDTH-1:0] pht_q [PHT_DEPTH];
    logic [CTR_WIDTH-1:0] pht_d [PHT_DEPTH];
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic                 pred_out_valid_q, pred_out_valid_d;
    logic                 pred_taken_q, pred_taken_d;
    logic [GHR_WIDTH-1:0] pred_ghr_q, pred_ghr_d;

    logic [PHT_WIDTH-1:0] pred_idx;
    logic [PHT_WIDTH-1:0] upd_idx;
    logic                 pred_bit;
    logic [CTR_WIDTH-1:0] upd_cur;
    logic [CTR_WIDTH-1:0] upd_nxt;
    // One bit wider than the GHR so the shift also works for GHR_WIDTH == 1.
    logic [GHR_WIDTH:0]   spec_ext;
    logic [GHR_WIDTH:0]   rest_ext;

    // Only the word-index bits of the addresses take part in the hash.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pred_addr[31:PHT_WIDTH+2], pred_addr[1:0],
                                upd_addr[31:PHT_WIDTH+2], upd_addr[1:0]};

    assign pred_idx = pred_addr[PHT_WIDTH+1:2] ^ PHT_WIDTH'(ghr_q);
    assign upd_idx  = upd_addr[PHT_WIDTH+1:2] ^ PHT_WIDTH'(upd_ghr);
    assign pred_bit = pht_q[pred_idx][CTR_WIDTH-1];
    assign upd_cur  = pht_q[upd_idx];
    assign spec_ext = {ghr_q, pred_bit};
    assign rest_ext = {upd_ghr, upd_taken};

    always_comb begin
        upd_nxt = upd_cur;
        if (upd_taken) begin
            if (upd_cur != CTR_MAX) upd_nxt = upd_cur + 1'b1;
        end else begin
            if (upd_cur != '0) upd_nxt = upd_cur - 1'b1;
        end
    end

    // Prediction reads pht_q, so a same-cycle update to the same entry is
    // seen only by later predictions (read-before-write).
    always_comb begin
        pht_d            = pht_q;
        ghr_d            = ghr_q;
        pred_out_valid_d = pred_out_valid_q;
        pred_taken_d     = pred_taken_q;
        pred_ghr_d       = pred_ghr_q;
        if (rdy_in) begin
            pred_out_valid_d = pred_valid;
            if (pred_valid) begin
                pred_taken_d = pred_bit;
                pred_ghr_d   = ghr_q;
                ghr_d        = spec_ext[GHR_WIDTH-1:0];
            end
            if (upd_valid) begin
                pht_d[upd_idx] = upd_nxt;
                // Restore overrides any speculative shift from this cycle.
                if (upd_mispredict) ghr_d = rest_ext[GHR_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= CTR_INIT;
            ghr_q            <= '0;
            pred_out_valid_q <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_ghr_q       <= '0;
        end else begin
            pht_q            <= pht_d;
            ghr_q            <= ghr_d;
            pred_out_valid_q <= pred_out_valid_d;
            pred_taken_q     <= pred_taken_d;
            pred_ghr_q       <= pred_ghr_d;
        end
    end

    assign pred_out_valid = pred_out_valid_q;
    assign pred_taken     = pred_taken_q;
    assign pred_ghr       = pred_ghr_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - self-checking bench for gshare_predictor
module tb_gshare_predictor;

    localparam int PW = 10;
    localparam int GW = 8;
    localparam int CW = 2;
    localparam int DEPTH = 1 << PW;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int CINIT = (1 << (CW - 1)) - 1;
    localparam int HMOD  = 1 << GW;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          rdy_in = 1'b1;
    logic          pred_valid = 1'b0;
    logic [31:0]   pred_addr = '0;
    logic          pred_out_valid;
    logic          pred_taken;
    logic [GW-1:0] pred_ghr;
    logic          upd_valid = 1'b0;
    logic [31:0]   upd_addr = '0;
    logic [GW-1:0] upd_ghr = '0;
    logic          upd_taken = 1'b0;
    logic          upd_mispredict = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integer counters and history value.
    int m_pht [DEPTH];
    int m_ghr;
    int m_ov, m_pt, m_pg;

    gshare_predictor #(.PHT_WIDTH(PW), .GHR_WIDTH(GW), .CTR_WIDTH(CW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .pred_valid(pred_valid), .pred_addr(pred_addr),
        .pred_out_valid(pred_out_valid), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
    );

    always #5 clk_in = ~clk_in;

    function automatic int hidx(input int unsigned addr, input int unsigned h);
        return int'(((addr / 4) ^ h) % DEPTH);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int nghr, p, i;
        if (rst_in) begin
            for (int k = 0; k < DEPTH; k++) m_pht[k] = CINIT;
            m_ghr = 0; m_ov = 0; m_pt = 0; m_pg = 0;
        end else if (rdy_in) begin
            nghr = m_ghr;
            p = (m_pht[hidx(pred_addr, m_ghr)] > CINIT) ? 1 : 0;
            m_ov = int'(pred_valid);
            if (pred_valid) begin
                m_pt = p;
                m_pg = m_ghr;
                nghr = (m_ghr * 2 + p) % HMOD;
            end
            if (upd_valid) begin
                i = hidx(upd_addr, upd_ghr);
                if (upd_taken) m_pht[i] = (m_pht[i] < CMAX) ? m_pht[i] + 1 : CMAX;
                else           m_pht[i] = (m_pht[i] > 0) ? m_pht[i] - 1 : 0;
                if (upd_mispredict) nghr = (int'(upd_ghr) * 2 + int'(upd_taken)) % HMOD;
            end
            m_ghr = nghr;
        end
    endtask

    // One clock: inputs already set; model and DUT advance; outputs compared.
    task automatic cycle();
        @(posedge clk_in);
        model_edge();
        #1;
        chk("model_valid", int'(pred_out_valid), m_ov);
        chk("model_taken", int'(pred_taken), m_pt);
        chk("model_ghr", int'(pred_ghr), m_pg);
        pred_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic predict(input logic [31:0] a);
        pred_valid = 1'b1; pred_addr = a;
        cycle();
    endtask

    task automatic update(input logic [31:0] a, input int g, input logic t, input logic mp);
        upd_valid = 1'b1; upd_addr = a; upd_ghr = GW'(g); upd_taken = t; upd_mispredict = mp;
        cycle();
    endtask

    // Restore through an entry nobody else uses in the directed part.
    task automatic force_ghr(input int g);
        update(32'h0000_1FFC, g / 2, g[0], 1'b1);
    endtask

    initial begin
        // Reset
        rst_in = 1'b1;
        cycle(); cycle();
        chk("reset_valid", int'(pred_out_valid), 0);
        chk("reset_taken", int'(pred_taken), 0);
        chk("reset_ghr", int'(pred_ghr), 0);
        rst_in = 1'b0;

        // First prediction: weakly not-taken, GHR stays 0
        predict(32'h0000_1000);
        chk("first_valid", int'(pred_out_valid), 1);
        chk("first_taken", int'(pred_taken), 0);
        chk("first_ghr", int'(pred_ghr), 0);
        predict(32'h0000_1000);
        chk("ghr_after_nt", int'(pred_ghr), 0);

        // Two taken updates -> taken prediction
        update(32'h0000_1000, 0, 1'b1, 1'b0);
        update(32'h0000_1000, 0, 1'b1, 1'b0);
        chk("idle_valid", int'(pred_out_valid), 0);
        predict(32'h0000_1000);
        chk("trained_taken", int'(pred_taken), 1);
        chk("trained_ghr", int'(pred_ghr), 0);
        // Saturation: 3rd taken stays 3, one not-taken leaves 2 -> still taken
        update(32'h0000_1000, 0, 1'b1, 1'b0);
        update(32'h0000_1000, 0, 1'b0, 1'b0);
        force_ghr(0);
        predict(32'h0000_1000);
        chk("sat_taken", int'(pred_taken), 1);

        // Four not-taken -> counter 0, no wrap; one taken -> 1 still not taken
        repeat (4) update(32'h0000_1000, 0, 1'b0, 1'b0);
        force_ghr(0);
        predict(32'h0000_1000);
        chk("floor_taken", int'(pred_taken), 0);
        update(32'h0000_1000, 0, 1'b1, 1'b0);
        force_ghr(0);
        predict(32'h0000_1000);
        chk("floor_nowrap", int'(pred_taken), 0);

        // Preload entries 0,1,3 taken, then three taken predictions -> GHR 7
        update(32'h0000_1000, 0, 1'b1, 1'b0);
        update(32'h0000_1000, 1, 1'b1, 1'b0);
        update(32'h0000_1000, 3, 1'b1, 1'b0);
        force_ghr(0);
        predict(32'h0000_1000);
        chk("spec1_taken", int'(pred_taken), 1);
        predict(32'h0000_1000);
        chk("spec2_ghr", int'(pred_ghr), 1);
        predict(32'h0000_1000);
        chk("spec3_ghr", int'(pred_ghr), 3);
        predict(32'h0000_2000);
        chk("spec_ghr7", int'(pred_ghr), 7);
        // Mispredict restore: upd_ghr=1, taken=0 -> GHR 2 (pred in same cycle discarded)
        pred_valid = 1'b1; pred_addr = 32'h0000_3000;
        update(32'h0000_1FFC, 1, 1'b0, 1'b1);
        predict(32'h0000_1000);
        chk("restore_ghr", int'(pred_ghr), 2);

        // Same-cycle update and predict on one index: read-before-write
        force_ghr(0);
        pred_valid = 1'b1; pred_addr = 32'h0000_2040;
        update(32'h0000_2040, 0, 1'b1, 1'b0);
        chk("rbw_old", int'(pred_taken), 0);
        force_ghr(0);
        predict(32'h0000_2040);
        chk("rbw_new", int'(pred_taken), 1);

        // rdy_in low: everything frozen, requests dropped
        rdy_in = 1'b0;
        repeat (3) begin
            pred_valid = 1'b1; pred_addr = 32'h0000_2040;
            update(32'h0000_2040, 1, 1'b0, 1'b1);
            chk("frozen_valid", int'(pred_out_valid), 1);
            chk("frozen_taken", int'(pred_taken), 1);
        end
        rdy_in = 1'b1;
        predict(32'h0000_2040);
        chk("frozen_ghr", int'(pred_ghr), 1);

        // Reset mid-stream
        pred_valid = 1'b1; pred_addr = 32'h0000_1000;
        rst_in = 1'b1;
        cycle();
        rst_in = 1'b0;
        chk("rst_mid_valid", int'(pred_out_valid), 0);
        chk("rst_mid_ghr", int'(pred_ghr), 0);
        predict(32'h0000_2040);
        chk("rst_mid_ctr", int'(pred_taken), 0);

        // Randomized traffic on a small address set to force collisions
        for (int n = 0; n < 600; n++) begin
            rdy_in         = ($urandom_range(0, 9) != 0);
            rst_in         = ($urandom_range(0, 199) == 0);
            pred_valid     = $urandom_range(0, 1);
            pred_addr      = {$urandom_range(0, 7), 2'b00} | ($urandom() & 32'hFFFF_0000);
            upd_valid      = $urandom_range(0, 1);
            upd_addr       = {$urandom_range(0, 7), 2'b00};
            upd_ghr        = GW'($urandom_range(0, 7));
            upd_taken      = $urandom_range(0, 1);
            upd_mispredict = ($urandom_range(0, 3) == 0);
            cycle();
        end
        rst_in = 1'b0; rdy_in = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
